// File: rtl/ahb_arb_pkg.sv
// rtl/ahb_arb_pkg.sv - shared AHB encodings and burst helpers for the output-stage arbiter
package ahb_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Beats still to come after the NONSEQ of a defined-length burst.
    function automatic logic [3:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: burst_beats = 4'd15;
            default:                      burst_beats = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_arb_rr_pick.sv
// rtl/ahb_arb_rr_pick.sv - combinational fixed-priority / round-robin request picker
module ahb_arb_rr_pick #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    rr_ptr_i,
    input  logic                 rr_mode_i,
    output logic [PORT_W-1:0]    grant_o,
    output logic                 valid_o
);

    always_comb begin
        grant_o = '0;
        valid_o = 1'b0;
        if (rr_mode_i) begin
            // Scan rr_ptr+1 .. rr_ptr+NUM_PORTS; the wrap is modulo NUM_PORTS, not 2^PORT_W.
            for (int k = 1; k <= NUM_PORTS; k++) begin
                for (int i = 0; i < NUM_PORTS; i++) begin
                    if (!valid_o && req_i[i] &&
                        ((int'(rr_ptr_i) + k == i) || (int'(rr_ptr_i) + k == i + NUM_PORTS))) begin
                        grant_o = PORT_W'(i);
                        valid_o = 1'b1;
                    end
                end
            end
        end else begin
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    grant_o = PORT_W'(i);
                    valid_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb_output_arbiter_param.sv
// rtl/ahb_output_arbiter_param.sv - parametrised AHB matrix output-stage arbiter with burst/lock hold
module ahb_output_arbiter_param
    import ahb_arb_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    parameter int ARB_MODE   = 0,
    parameter int BURST_HOLD = 1
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port,
    output logic                 burst_hold
);

    logic [PORT_W-1:0]    addr_q, addr_d;
    logic                 no_port_q, no_port_d;
    logic                 burst_hold_q, burst_hold_d;
    logic [3:0]           beat_cnt_q, beat_cnt_d;
    logic                 incr_hold_q, incr_hold_d;
    logic [PORT_W-1:0]    rr_ptr_q, rr_ptr_d;

    logic [NUM_PORTS-1:0] cur_onehot;
    logic [NUM_PORTS-1:0] eff_req;
    logic                 cur_active;
    logic                 is_seq, is_busy;
    logic                 hold_now;
    logic                 arb_en;
    logic [PORT_W-1:0]    pick_idx;
    logic                 pick_valid;

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            cur_onehot[i] = (addr_q == PORT_W'(i));
        end
    end

    // The selected port keeps an implicit request while it is mid-transfer.
    assign cur_active = HSELM && (HTRANSM != HTRANS_IDLE) && !no_port_q;
    assign eff_req    = req_port | (cur_onehot & {NUM_PORTS{cur_active}});

    assign is_seq  = (HTRANSM == HTRANS_SEQ);
    assign is_busy = (HTRANSM == HTRANS_BUSY);

    // The last SEQ beat (count 1 -> 0) releases, so another port may win on that edge.
    assign hold_now = ((beat_cnt_q > 4'd1) && is_seq)
                    || ((beat_cnt_q != 4'd0) && is_busy)
                    || (incr_hold_q && (is_seq || is_busy));

    assign arb_en = !HMASTLOCKM && !((BURST_HOLD != 0) && hold_now);

    ahb_arb_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req_i     (eff_req),
        .rr_ptr_i  (rr_ptr_q),
        .rr_mode_i (ARB_MODE == ARB_RR),
        .grant_o   (pick_idx),
        .valid_o   (pick_valid)
    );

    always_comb begin
        addr_d    = addr_q;
        no_port_d = no_port_q;
        rr_ptr_d  = rr_ptr_q;
        if (arb_en) begin
            if (pick_valid) begin
                addr_d    = pick_idx;
                no_port_d = 1'b0;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr_d = pick_idx;
                end
            end else if (HSELM) begin
                no_port_d = 1'b0;
            end else begin
                no_port_d = 1'b1;
            end
        end
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        incr_hold_d = incr_hold_q;
        if (!no_port_q) begin
            case (HTRANSM)
                HTRANS_NONSEQ: begin
                    beat_cnt_d  = burst_beats(HBURSTM);
                    incr_hold_d = (HBURSTM == HBURST_INCR);
                end
                HTRANS_SEQ: begin
                    if (beat_cnt_q != 4'd0) begin
                        beat_cnt_d = beat_cnt_q - 4'd1;
                    end
                end
                HTRANS_IDLE: begin
                    beat_cnt_d  = 4'd0;
                    incr_hold_d = 1'b0;
                end
                default: ;
            endcase
        end
        // Burst tracking belongs to the old owner; a new owner starts clean.
        if (!no_port_d && (no_port_q || (addr_d != addr_q))) begin
            beat_cnt_d  = 4'd0;
            incr_hold_d = 1'b0;
        end
        burst_hold_d = (beat_cnt_d != 4'd0) || incr_hold_d;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            addr_q       <= '0;
            no_port_q    <= 1'b1;
            burst_hold_q <= 1'b0;
            beat_cnt_q   <= 4'd0;
            incr_hold_q  <= 1'b0;
            rr_ptr_q     <= PORT_W'(NUM_PORTS - 1);
        end else if (HREADYM) begin
            addr_q       <= addr_d;
            no_port_q    <= no_port_d;
            burst_hold_q <= burst_hold_d;
            beat_cnt_q   <= beat_cnt_d;
            incr_hold_q  <= incr_hold_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;
    assign burst_hold   = burst_hold_q;

endmodule

// File: tb/tb_ahb_output_arbiter_param.sv
// tb/tb_ahb_output_arbiter_param.sv - scoreboard bench for fixed/round-robin builds of the output arbiter
module tb_ahb_output_arbiter_param;

    localparam logic [1:0] IDL = 2'b00;
    localparam logic [1:0] BSY = 2'b01;
    localparam logic [1:0] NSQ = 2'b10;
    localparam logic [1:0] SQ  = 2'b11;
    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_INCR16 = 3'b111;

    logic       clk = 1'b0;
    logic       rstn;
    logic [3:0] req;
    logic       rdy, sel, lock;
    logic [1:0] trans;
    logic [2:0] burst;

    logic [1:0] a0, a1, a2;
    logic       np0, np1, np2, bh0, bh1, bh2;

    always #5 clk = ~clk;

    ahb_output_arbiter_param #(.NUM_PORTS(4), .ARB_MODE(0), .BURST_HOLD(1)) u0 (
        .HCLK(clk), .HRESETn(rstn), .req_port(req), .HREADYM(rdy), .HSELM(sel),
        .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
        .addr_in_port(a0), .no_port(np0), .burst_hold(bh0));

    ahb_output_arbiter_param #(.NUM_PORTS(4), .ARB_MODE(1), .BURST_HOLD(1)) u1 (
        .HCLK(clk), .HRESETn(rstn), .req_port(req), .HREADYM(rdy), .HSELM(sel),
        .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
        .addr_in_port(a1), .no_port(np1), .burst_hold(bh1));

    ahb_output_arbiter_param #(.NUM_PORTS(3), .ARB_MODE(1), .BURST_HOLD(1)) u2 (
        .HCLK(clk), .HRESETn(rstn), .req_port(req[2:0]), .HREADYM(rdy), .HSELM(sel),
        .HTRANSM(trans), .HBURSTM(burst), .HMASTLOCKM(lock),
        .addr_in_port(a2), .no_port(np2), .burst_hold(bh2));

    typedef struct {
        int         id;
        int         inst;
        logic       np;
        logic [3:0] a;
        logic       bh;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Each step owns one clock edge; the monitor pops one expectation per edge.
    task automatic step(input logic [3:0] r, input logic s, input logic [1:0] t, input logic [2:0] b,
                        input logic l, input logic rd, input logic rn, input int inst,
                        input logic np, input logic [3:0] a, input logic bh);
        exp_t e;
        @(negedge clk);
        req = r; sel = s; trans = t; burst = b; lock = l; rdy = rd; rstn = rn;
        e.id = step_id; e.inst = inst; e.np = np; e.a = a; e.bh = bh;
        exp_q.push_back(e);
        step_id++;
    endtask

    task automatic do_reset(input int inst);
        step(4'b0000, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b0, inst, 1'b1, 4'd0, 1'b0);
    endtask

    initial begin
        exp_t       e;
        logic       gnp, gbh;
        logic [3:0] ga;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.inst)
                    0:       begin gnp = np0; ga = {2'b00, a0}; gbh = bh0; end
                    1:       begin gnp = np1; ga = {2'b00, a1}; gbh = bh1; end
                    default: begin gnp = np2; ga = {2'b00, a2}; gbh = bh2; end
                endcase
                checks++;
                if (gnp !== e.np || ga !== e.a || gbh !== e.bh) begin
                    errors++;
                    $display("FAIL step%0d u%0d got np=%0b addr=%0d bh=%0b want np=%0b addr=%0d bh=%0b",
                             e.id, e.inst, gnp, ga, gbh, e.np, e.a, e.bh);
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; req = '0; rdy = 1'b1; sel = 1'b0; lock = 1'b0; trans = IDL; burst = B_SINGLE;

        // Fixed priority: lowest index wins; no request and no select drops to no_port.
        do_reset(0);
        step(4'b1010, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd1, 1'b0);
        step(4'b1011, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0);
        step(4'b0000, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b1, 4'd0, 1'b0);

        // Round-robin over four ports, then a three-port build that must wrap at 2.
        do_reset(1);
        for (int i = 0; i < 5; i++)
            step(4'b1111, 1'b1, NSQ, B_SINGLE, 1'b0, 1'b1, 1'b1, 1, 1'b0, 4'(i % 4), 1'b0);
        do_reset(2);
        for (int i = 0; i < 5; i++)
            step(4'b1111, 1'b1, NSQ, B_SINGLE, 1'b0, 1'b1, 1'b1, 2, 1'b0, 4'(i % 3), 1'b0);

        // INCR4 on port 2 holds against port 0 until the last SEQ is accepted.
        do_reset(0);
        step(4'b0100, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b0);
        step(4'b0100, 1'b1, NSQ, B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0);

        // Same burst stretched by two wait states.
        do_reset(0);
        step(4'b0100, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b0);
        step(4'b0100, 1'b1, NSQ, B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b0, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b0, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR4,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0);

        // Lock on port 1 for five beats; port 0 wins on the first unlocked edge.
        do_reset(0);
        step(4'b0010, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 5; i++)
            step(4'b0011, 1'b1, NSQ, B_SINGLE, 1'b1, 1'b1, 1'b1, 0, 1'b0, 4'd1, 1'b0);
        step(4'b0011, 1'b1, NSQ, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0);

        // INCR8 on port 3 cut short by IDLE after two SEQ beats.
        do_reset(0);
        step(4'b1000, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd3, 1'b0);
        step(4'b1000, 1'b1, NSQ, B_INCR8,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd3, 1'b1);
        step(4'b1001, 1'b1, SQ,  B_INCR8,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd3, 1'b1);
        step(4'b1001, 1'b1, SQ,  B_INCR8,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd3, 1'b1);
        step(4'b1001, 1'b1, IDL, B_INCR8,  1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0);

        // Undefined-length INCR holds through SEQ and BUSY until IDLE.
        do_reset(0);
        step(4'b0100, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b0);
        step(4'b0100, 1'b1, NSQ, B_INCR,   1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR,   1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, BSY, B_INCR,   1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, SQ,  B_INCR,   1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0101, 1'b1, IDL, B_INCR,   1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd0, 1'b0);

        // Reset in the middle of INCR16, then nothing requests.
        do_reset(0);
        step(4'b0100, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b0);
        step(4'b0100, 1'b1, NSQ, B_INCR16, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0100, 1'b1, SQ,  B_INCR16, 1'b0, 1'b1, 1'b1, 0, 1'b0, 4'd2, 1'b1);
        step(4'b0100, 1'b1, SQ,  B_INCR16, 1'b0, 1'b1, 1'b0, 0, 1'b1, 4'd0, 1'b0);
        step(4'b0000, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b1, 4'd0, 1'b0);
        step(4'b0000, 1'b0, IDL, B_SINGLE, 1'b0, 1'b1, 1'b1, 0, 1'b1, 4'd0, 1'b0);

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
